shift_iter: RTL and testbench
=============================

Name: shift_iter

Overview:
- Multi-cycle serial shift unit for the 16-bit datapath.
- Wraps a single-bit shift stage in a feedback loop and applies one bit-position of shift per clock until the requested amount is done.
- Uses the same shift-op encoding as the single-bit shifter stage. Consumes that stage's output each cycle and feeds it back as the next input.
- Sits between decode/operand read and writeback, as a low-area alternative to a full barrel shifter. It has a start/busy/valid handshake.

Parameters:
- WIDTH, 16, data width in bits.
- CNT_W, 4, shift-amount width; maximum shift is 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- in  input  WIDTH  operand.
- op  input  3  000 rol, 001 ror, 010 sll, 011 sra, 100 srl, 101-111 illegal.
- cnt  input  CNT_W  shift amount.
- busy  output  1  high while an operation is in flight, including the valid cycle.
- valid  output  1  one-cycle pulse: result present on out.
- err  output  1  pulses with valid when the accepted op was illegal.
- out  output  WIDTH  result register; holds until the next result is written.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - state=IDLE; busy=0, valid=0, err=0, out=16'h0000.
  - Internal working register and counter cleared.
  - Operation in flight is abandoned, with no valid pulse.
- Internal state: working register wr[WIDTH-1:0], down-counter ctr[CNT_W-1:0], latched op.
- IDLE:
  - busy=0. On clk edge with start=1:
    - wr<=in, ctr<=cnt, op latched.
    - op illegal -> DONE with err flag set (cnt ignored).
    - else cnt==0 -> DONE.
    - else -> SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT:
  - busy=1. Each edge: wr<=shift1(wr, op), ctr<=ctr-1.
  - When ctr==1 at the edge, the shift is applied and next state is DONE.
- DONE:
  - busy=1, valid=1 for exactly one cycle. err=1 iff the latched op was illegal.
  - out was loaded on the edge entering DONE: wr for legal ops, 16'h0000 for illegal ops.
  - Next state is IDLE unconditionally.
- shift1 rules, one bit position per cycle:
  - rol: {wr[14:0], wr[15]}
  - ror: {wr[0], wr[15:1]}
  - sll: {wr[14:0], 0}
  - sra: {wr[15], wr[15:1]}
  - srl: {0, wr[15:1]}
- Latency: valid asserts cnt+1 cycles after the accepting edge (1 cycle for cnt=0 or an illegal op). busy is high for exactly cnt+1 cycles.
- Handshake:
  - start while busy=1, including the DONE/valid cycle, is ignored and not queued.
  - in/op/cnt need only be stable at the accepting edge.
- Outputs busy, valid and err are registered or decoded from state only; there is no combinational path from inputs.
- Boundaries:
  - cnt=15 gives 16 cycles of latency; rol/ror by 15 equal a 1-bit shift in the opposite direction.
  - sra of a negative value saturates to 16'hFFFF.
  - out is unchanged between results.

Optional Feature:
- Macro EARLY_TERM_EN.
- Defined:
  - In SHIFT, before shifting, a saturation check is made on wr:
    - sll/srl: wr==0.
    - sra: wr==0 or wr==16'hFFFF.
    - rol/ror: wr==0 or wr==16'hFFFF.
  - If the check is true, go to DONE without shifting: out<=wr, and ctr is discarded.
  - Result is identical to the non-terminated case; latency is shortened.
- Undefined: no check logic is present; latency is always cnt+1.

Test Plan:
1. in=16'h8001, op=000, cnt=1 -> 2 cycles after start: valid=1, err=0, out=16'h0003; busy high for those 2 cycles.
2. in=16'h8000, op=011, cnt=4 -> valid exactly 5 cycles after start, out=16'hF800; in=16'h8000, op=100, cnt=15 -> out=16'h0001 after 16 cycles.
3. in=16'h1234, op=010, cnt=0 -> valid 1 cycle after start, out=16'h1234; out still 16'h1234 ten cycles later with no start.
4. op=3'b101, cnt=7, in=16'hFFFF -> 1 cycle later valid=1, err=1, out=16'h0000; next legal op gives err=0.
5. Two starts 2 cycles apart with cnt=5: second start ignored, single valid at cycle 6. rst_n pulsed low during SHIFT: busy, valid, err and out go to 0 immediately with no clock edge, and no valid follows.
6. EARLY_TERM_EN defined: in=16'h0001, op=100, cnt=15 -> valid at cycle 3, out=16'h0000. Undefined: valid at cycle 16, same out.

Source files
------------

// File: rtl/shift_iter.sv
`default_nettype none
// ============================================================================
// Module      : shift_iter
// Description : Multi-cycle serial shifter. A single-bit shift stage sits in
//               a feedback loop and is applied once per clock until the
//               requested shift amount is consumed. It uses a start/busy/valid
//               handshake.
//               Optional macro EARLY_TERM_EN: stop shifting as soon as the
//               working value can no longer change under the latched op.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] out
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] ctr_q, ctr_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] shifted;

  // Single-bit shift stage; its output is fed back into wr every SHIFT cycle.
  always_comb begin
    shifted = wr_q;
    case (op_q)
      OP_ROL:  shifted = {wr_q[WIDTH-2:0], wr_q[WIDTH-1]};
      OP_ROR:  shifted = {wr_q[0], wr_q[WIDTH-1:1]};
      OP_SLL:  shifted = {wr_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shifted = {wr_q[WIDTH-1], wr_q[WIDTH-1:1]};
      OP_SRL:  shifted = {1'b0, wr_q[WIDTH-1:1]};
      default: shifted = wr_q;
    endcase
  end

`ifdef EARLY_TERM_EN
  logic saturated;

  // A value is a fixed point of the op: all-zero for every op, all-ones for
  // everything except the logical shifts, which would still pull in zeros.
  always_comb begin
    saturated = (wr_q == '0);
    if (op_q == OP_ROL || op_q == OP_ROR || op_q == OP_SRA) begin
      saturated = saturated || (wr_q == '1);
    end
  end
`endif

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ctr_d   = ctr_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_d  = in;
          ctr_d = cnt;
          op_d  = op;
          if (op > OP_SRL) begin
            // Illegal op: report immediately, shift amount ignored.
            state_d = S_DONE;
            out_d   = '0;
          end else if (cnt == '0) begin
            state_d = S_DONE;
            out_d   = in;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
`ifdef EARLY_TERM_EN
        if (saturated) begin
          state_d = S_DONE;
          out_d   = wr_q;
          ctr_d   = '0;
        end else
`endif
        begin
          wr_d  = shifted;
          ctr_d = ctr_q - CNT_W'(1);
          if (ctr_q == CNT_W'(1)) begin
            state_d = S_DONE;
            out_d   = shifted;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      ctr_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ctr_q   <= ctr_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = (state_q == S_DONE);
  assign err   = (state_q == S_DONE) && (op_q > OP_SRL);
  assign out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_iter
// Description : Self-checking bench for shift_iter. Directed cases plus
//               randomized operations compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic [2:0]  op;
  logic [3:0]  cnt;
  logic        busy;
  logic        valid;
  logic        err;
  logic [15:0] out;

  int n_checks;
  int n_fail;

  shift_iter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .op    (op),
    .cnt   (cnt),
    .busy  (busy),
    .valid (valid),
    .err   (err),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result of shifting x by n positions under op, by plain arithmetic.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [2:0] o, input int n);
    logic [31:0] dbl;
    logic [31:0] tmp;
    logic signed [15:0] sx;
    dbl = {x, x};
    sx  = x;
    case (o)
      3'd0: begin tmp = dbl << n; return tmp[31:16]; end
      3'd1: begin tmp = dbl >> n; return tmp[15:0]; end
      3'd2: return x << n;
      3'd3: return 16'(sx >>> n);
      3'd4: return x >> n;
      default: return 16'h0000;
    endcase
  endfunction

  // Cycles from the accepting edge until valid is visible.
  function automatic int model_lat(input logic [15:0] x, input logic [2:0] o, input int n);
    if (o > 3'd4) return 1;
`ifdef EARLY_TERM_EN
    for (int k = 0; k < n; k++) begin
      logic [15:0] v;
      v = model(x, o, k);
      if (v == 16'h0000 || (o != 3'd2 && o != 3'd4 && v == 16'hFFFF)) return k + 2;
    end
`endif
    return n + 1;
  endfunction

  // Issue one operation and check latency, result, err and busy shape.
  // With noise set, start and operands are scrambled while busy.
  task automatic run_op(input logic [15:0] x, input logic [2:0] o, input logic [3:0] c,
                        input bit noise, input string tag);
    int n;
    int exp_lat;
    bit busy_ok;
    logic [15:0] exp_out;
    exp_lat = model_lat(x, o, int'(c));
    exp_out = model(x, o, int'(c));
    @(negedge clk);
    in = x; op = o; cnt = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in = 16'($urandom); op = 3'($urandom); cnt = 4'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (!valid && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (noise) start = (n == 2) ? 1'b1 : 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_err"}, err, (o > 3'd4) ? 1 : 0);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {busy, valid, err}, 3'b000);
    chk({tag, "_hold"}, out, exp_out);
  endtask

  initial begin
    bit seen;
    logic [15:0] last;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; in = 16'h0; op = 3'd0; cnt = 4'd0;
    #12;
    chk("rst_state", {busy, valid, err, out}, 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_idle", {busy, valid, err, out}, 19'd0);

    run_op(16'h8001, 3'd0, 4'd1, 1'b0, "rol1");
    run_op(16'h8000, 3'd3, 4'd4, 1'b0, "sra4");
    run_op(16'h8000, 3'd4, 4'd15, 1'b0, "srl15");
    run_op(16'h1234, 3'd2, 4'd0, 1'b0, "sll0");
    repeat (10) @(posedge clk);
    #1;
    chk("hold10", out, 16'h1234);
    run_op(16'hFFFF, 3'd5, 4'd7, 1'b0, "ill");
    run_op(16'h00F0, 3'd1, 4'd3, 1'b0, "ror3");
    run_op(16'h8421, 3'd0, 4'd15, 1'b0, "rol15");
    run_op(16'h8421, 3'd1, 4'd15, 1'b0, "ror15");
    run_op(16'h9000, 3'd3, 4'd15, 1'b0, "sra_sat");
    run_op(16'h5A5A, 3'd2, 4'd5, 1'b1, "dbl_start");
    run_op(16'h0001, 3'd4, 4'd15, 1'b0, "early");
    run_op(16'hFFFF, 3'd4, 4'd2, 1'b0, "srl_ones");
    run_op(16'hFFFF, 3'd0, 4'd6, 1'b0, "rol_ones");
    run_op(16'h0000, 3'd2, 4'd9, 1'b0, "sll_zero");

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    in = 16'hABCD; op = 3'd2; cnt = 4'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {busy, valid, err, out}, 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", {31'd0, seen}, 32'd0);
    chk("mid_rst_out", out, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] x;
      logic [2:0]  o;
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        0: x = 16'h0000;
        1: x = 16'hFFFF;
        2: x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      run_op(x, o, 4'($urandom), 1'($urandom), "rnd");
      if (i % 25 == 0) begin
        last = out;
        repeat (3) @(posedge clk);
        #1;
        chk("rnd_hold", out, last);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
